// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add MUL and restoring DIV/REM; result and NZCV flags held until consumed.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 alu_op,
  input  logic [WIDTH-1:0]           operand_a,
  input  logic [WIDTH-1:0]           operand_b,
  input  logic [$clog2(WIDTH)-1:0]   shift_amt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       zero_flag,
  output logic                       neg_flag,
  output logic                       carry_flag,
  output logic                       ovf_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [4:0] OP_PASS  = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_RSB   = 5'b00011;
  localparam logic [4:0] OP_PASS2 = 5'b00100;
  localparam logic [4:0] OP_CLZ   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_LSL   = 5'b00111;
  localparam logic [4:0] OP_LSRI  = 5'b01000;
  localparam logic [4:0] OP_CMP   = 5'b01001;
  localparam logic [4:0] OP_ORR   = 5'b01010;
  localparam logic [4:0] OP_LSR   = 5'b01011;
  localparam logic [4:0] OP_CMPR  = 5'b01100;
  localparam logic [4:0] OP_MUL   = 5'b01101;
  localparam logic [4:0] OP_DIV   = 5'b01110;
  localparam logic [4:0] OP_REM   = 5'b01111;
  localparam logic [4:0] OP_ROR   = 5'b10000;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready only in IDLE, out_valid only in DONE, result held there.
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             is_iter_op;
  logic             last_iter;
  logic [SHW-1:0]   cnt_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;

  assign accept     = in_valid & in_ready;
  assign is_iter_op = (alu_op == OP_MUL) || (alu_op == OP_DIV) || (alu_op == OP_REM);
  assign last_iter  = (cnt_q == LAST_ITER);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_iter_op ? S_ITER : S_DONE;
      S_ITER: if (last_iter) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   sum_ab, diff_ab, diff_ba;
  logic             add_v, sub_v, rsb_v;
  logic [WIDTH-1:0] clz;
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_v;

  assign sum_ab  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_ab = {1'b0, operand_a} - {1'b0, operand_b};
  assign diff_ba = {1'b0, operand_b} - {1'b0, operand_a};
  assign add_v = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                 (sum_ab[WIDTH-1] != operand_a[WIDTH-1]);
  assign sub_v = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                 (diff_ab[WIDTH-1] != operand_a[WIDTH-1]);
  assign rsb_v = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                 (diff_ba[WIDTH-1] != operand_b[WIDTH-1]);

  // Highest set bit wins because the scan runs upward.
  always_comb begin
    clz = WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (operand_a[i]) clz = WIDTH'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (alu_op)
      OP_PASS, OP_PASS2: s_res = operand_a;
      OP_ADD: begin
        s_res = sum_ab[WIDTH-1:0];
        s_c   = sum_ab[WIDTH];
        s_v   = add_v;
      end
      OP_SUB, OP_CMP, OP_CMPR: begin
        s_res = diff_ab[WIDTH-1:0];
        s_c   = ~diff_ab[WIDTH];
        s_v   = sub_v;
      end
      OP_RSB: begin
        s_res = diff_ba[WIDTH-1:0];
        s_c   = ~diff_ba[WIDTH];
        s_v   = rsb_v;
      end
      OP_CLZ:  s_res = clz;
      OP_AND:  s_res = operand_a & operand_b;
      OP_ORR:  s_res = operand_a | operand_b;
      OP_LSL:  s_res = operand_a << shift_amt;
      OP_LSRI: s_res = operand_a >> shift_amt;
      OP_LSR:  s_res = operand_a >> operand_b[SHW-1:0];
      OP_ROR:  s_res = (operand_a >> shift_amt) | (operand_a << (WIDTH - int'(shift_amt)));
      default: s_res = '0;
    endcase
  end

  // ---------------- iterative datapath ----------------
  // MUL: {acc_hi, acc_lo} is the partial product, multiplier bits leave acc_lo.
  // DIV/REM: acc_hi is the partial remainder, acc_lo turns from dividend into quotient.
  logic [WIDTH:0]   mul_sum, mul_hi_n, div_shift, div_trial, div_hi_n;
  logic [WIDTH-1:0] mul_lo_n, div_lo_n;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] it_res;
  logic             it_c, it_v;

  always_comb begin
    mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_n  = {1'b0, mul_sum[WIDTH:1]};
    mul_lo_n  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    // A zero divisor never borrows, which yields quotient all-ones and remainder A.
    if (!div_trial[WIDTH]) begin
      div_hi_n = div_trial;
      div_lo_n = {acc_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_n = div_shift;
      div_lo_n = {acc_lo_q[WIDTH-2:0], 1'b0};
    end
    step_hi = (op_q == OP_MUL) ? mul_hi_n : div_hi_n;
    step_lo = (op_q == OP_MUL) ? mul_lo_n : div_lo_n;
    case (op_q)
      OP_MUL:  it_res = mul_lo_n;
      OP_DIV:  it_res = div_lo_n;
      default: it_res = div_hi_n[WIDTH-1:0];
    endcase
    it_c = (op_q == OP_MUL) && (|mul_hi_n[WIDTH-1:0]);
    it_v = (op_q != OP_MUL) && (opnd_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      result     <= '0;
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else if (accept) begin
      op_q  <= alu_op;
      cnt_q <= '0;
      if (is_iter_op) begin
        opnd_q   <= (alu_op == OP_MUL) ? operand_a : operand_b;
        acc_hi_q <= '0;
        acc_lo_q <= (alu_op == OP_MUL) ? operand_b : operand_a;
      end else begin
        result     <= s_res;
        zero_flag  <= (s_res == '0);
        neg_flag   <= s_res[WIDTH-1];
        carry_flag <= s_c;
        ovf_flag   <= s_v;
      end
    end else if (state_q == S_ITER) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q + SHW'(1);
      if (last_iter) begin
        result     <= it_res;
        zero_flag  <= (it_res == '0);
        neg_flag   <= it_res[WIDTH-1];
        carry_flag <= it_c;
        ovf_flag   <= it_v;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed and random ops on WIDTH=8 and WIDTH=16 instances,
// checked against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, sel16;
  logic [4:0]  alu_op;
  logic [15:0] opa, opb;
  logic [3:0]  sh;

  logic        in_ready8, out_valid8, z8, n8, c8, v8;
  logic [7:0]  result8;
  logic        in_ready16, out_valid16, z16, n16, c16, v16;
  logic [15:0] result16;

  logic        obs_ready, obs_valid, obs_z, obs_n, obs_c, obs_v;
  logic [15:0] obs_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel16), .in_ready(in_ready8),
    .alu_op(alu_op), .operand_a(opa[7:0]), .operand_b(opb[7:0]), .shift_amt(sh[2:0]),
    .out_valid(out_valid8), .out_ready(out_ready & ~sel16), .result(result8),
    .zero_flag(z8), .neg_flag(n8), .carry_flag(c8), .ovf_flag(v8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel16), .in_ready(in_ready16),
    .alu_op(alu_op), .operand_a(opa), .operand_b(opb), .shift_amt(sh),
    .out_valid(out_valid16), .out_ready(out_ready & sel16), .result(result16),
    .zero_flag(z16), .neg_flag(n16), .carry_flag(c16), .ovf_flag(v16)
  );

  assign obs_ready = sel16 ? in_ready16  : in_ready8;
  assign obs_valid = sel16 ? out_valid16 : out_valid8;
  assign obs_res   = sel16 ? result16    : {8'h00, result8};
  assign obs_z     = sel16 ? z16 : z8;
  assign obs_n     = sel16 ? n16 : n8;
  assign obs_c     = sel16 ? c16 : c8;
  assign obs_v     = sel16 ? v16 : v8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on a w-bit machine.
  function automatic void model(input int w, input int op, input int a, input int b,
                                input int s, output int res, output int c, output int v);
    int mask, half, sa, sb, d;
    longint p;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    res = 0; c = 0; v = 0;
    case (op)
      0, 4: res = a;
      1: begin
        res = (a + b) & mask; c = (a + b > mask) ? 1 : 0;
        v = (sa + sb > half - 1 || sa + sb < -half) ? 1 : 0;
      end
      2, 9, 12: begin
        res = (a - b) & mask; c = (a >= b) ? 1 : 0;
        v = (sa - sb > half - 1 || sa - sb < -half) ? 1 : 0;
      end
      3: begin
        res = (b - a) & mask; c = (b >= a) ? 1 : 0;
        v = (sb - sa > half - 1 || sb - sa < -half) ? 1 : 0;
      end
      5: begin
        d = 0;
        while (d < w && (((a >> (w - 1 - d)) & 1) == 0)) d++;
        res = d;
      end
      6:  res = a & b;
      10: res = a | b;
      7:  res = (a << s) & mask;
      8:  res = a >> s;
      11: res = a >> (b % w);
      13: begin
        p = longint'(a) * longint'(b);
        res = int'(p & longint'(mask)); c = ((p >> w) != 0) ? 1 : 0;
      end
      14: if (b == 0) begin res = mask; v = 1; end else res = a / b;
      15: if (b == 0) begin res = a; v = 1; end else res = a % b;
      16: res = ((a >> s) | (a << (w - s))) & mask;
      default: res = 0;
    endcase
  endfunction

  task automatic run_op(input int op, input int a, input int b, input int s, input int hold);
    int w, exp_res, exp_c, exp_v, exp_lat, lat, n;
    bit busy_ok;
    w = sel16 ? 16 : 8;
    model(w, op, a, b, s, exp_res, exp_c, exp_v);
    exp_lat = (op >= 13 && op <= 15) ? w + 1 : 1;
    n = 0;
    @(negedge clk);
    while (!obs_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_idle", 32'(obs_ready), 32'd1);
    alu_op = 5'(op); opa = 16'(a); opb = 16'(b); sh = 4'(s); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (obs_ready) busy_ok = 1'b0;
    end while (!obs_valid && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_in_ready_low", 32'(busy_ok), 32'd1);
    chk("result", 32'(obs_res), 32'(exp_res));
    chk("zero_flag", 32'(obs_z), 32'(exp_res == 0));
    chk("neg_flag", 32'(obs_n), 32'((exp_res >> (w - 1)) & 1));
    chk("carry_flag", 32'(obs_c), 32'(exp_c));
    chk("ovf_flag", 32'(obs_v), 32'(exp_v));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      alu_op = 5'd1; opa = 16'($urandom); opb = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(obs_valid), 32'd1);
      chk("hold_in_ready", 32'(obs_ready), 32'd0);
      chk("hold_result", 32'(obs_res), 32'(exp_res));
      chk("hold_flags", {28'd0, obs_z, obs_n, obs_c, obs_v},
          {28'd0, 1'(exp_res == 0), 1'((exp_res >> (w - 1)) & 1), 1'(exp_c), 1'(exp_v)});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("drained", 32'(obs_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a, b, s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel16 = 1'b0;
    alu_op = '0; opa = '0; opb = '0; sh = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(obs_ready), 32'd0);
    chk("rst_out_valid", 32'(obs_valid), 32'd0);
    chk("rst_result", 32'(obs_res), 32'd0);
    chk("rst_flags", {28'd0, obs_z, obs_n, obs_c, obs_v}, 32'd0);
    rst_n = 1'b1;

    run_op(1, 8'h7F, 8'h01, 0, 0);
    run_op(2, 8'h00, 8'h01, 0, 0);
    run_op(9, 8'h05, 8'h05, 0, 0);
    run_op(13, 8'h10, 8'h11, 0, 0);
    run_op(14, 200, 7, 0, 0);
    run_op(15, 200, 7, 0, 0);
    run_op(14, 5, 0, 0, 0);
    run_op(15, 5, 0, 0, 0);
    run_op(5, 8'h00, 0, 0, 0);
    run_op(16, 8'h81, 0, 3, 0);
    run_op(1, 8'h3C, 8'h55, 0, 5);

    // Reset in the third iteration cycle of a MUL.
    run_op(1, 8'h12, 8'h34, 0, 0);
    @(negedge clk);
    alu_op = 5'd13; opa = 16'h0F; opb = 16'h0F; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(obs_valid), 32'd0);
    chk("midrst_result", 32'(obs_res), 32'd0);
    chk("midrst_in_ready", 32'(obs_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(13, 8'h0F, 8'h0F, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 17));
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 7));
      run_op(op, a, b, s, (i % 8 == 3) ? 2 : 0);
    end

    sel16 = 1'b1;
    run_op(16, 16'h0001, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      op = int'($urandom_range(0, 16));
      a = int'($urandom_range(0, 65535));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 65535));
      s = int'($urandom_range(0, 15));
      run_op(op, a, b, s, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
